// File: rtl/pad_vdd_seq_pkg.sv
// Shared definitions for the switchable supply pad block.
// Contents: sequencer state encoding and the channel-count ceiling that
// sizes each per-pad instance ID range.
package pad_pkg;

  typedef enum logic [2:0] {
    PS_OFF,
    PS_UP,
    PS_ON,
    PS_DOWN,
    PS_FAULT
  } pad_seq_state_e;

  localparam int PAD_NCH_MAX = 16;

endpackage

// File: rtl/pad_vdd_seq_sw.sv
// Single switchable supply pad.
// Ports:
//   drv : 1 = drive the pad to 1'b1, 0 = release it (high impedance)
//   pad : supply pad
module pad_vdd_sw #(
  parameter int ID = 0
) (
  input  logic drv,
  inout  logic pad
);

  if (ID < 0) begin : g_bad_id
    $error("pad_vdd_sw: ID must be non-negative");
  end

  assign pad = drv ? 1'b1 : 1'bz;

endmodule

// File: rtl/pad_vdd_seq.sv
// Sequenced multi-channel VDD supply pad block.
// Powers channels up in ascending order and down in descending order with
// DLY settle cycles per step; any over-current on a driven channel latches
// a fault that releases every pad until the power request is withdrawn.
// Ports:
//   clk   : block clock
//   rst_n : asynchronous active-low reset
//   en    : power request (1 = sequence up / stay on, 0 = sequence down)
//   ovc   : per-channel over-current flags, synchronous to clk
//   pad   : supply pads, 1'b1 when driven, 1'bz otherwise
//   pgood : per-channel powered-and-settled
//   ready : all channels good
//   busy  : sequencing up or down
//   fault : over-current shutdown latched
module pad_vdd_seq
  import pad_pkg::*;
#(
  parameter int ID   = 0,
  parameter int NCH  = 4,
  parameter int DLYW = 8,
  parameter int DLY  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [NCH-1:0] ovc,
  inout  logic [NCH-1:0] pad,
  output logic [NCH-1:0] pgood,
  output logic           ready,
  output logic           busy,
  output logic           fault
);

  if (NCH < 1 || NCH > PAD_NCH_MAX) begin : g_bad_nch
    $error("pad_vdd_seq: NCH out of range 1..16");
  end
  if (DLY < 1 || DLY > (2**DLYW) - 1) begin : g_bad_dly
    $error("pad_vdd_seq: DLY out of range 1..2**DLYW-1");
  end

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0]   IDX_LAST = IW'(NCH - 1);
  localparam logic [DLYW-1:0] CNT_LAST = DLYW'(DLY - 1);

  pad_seq_state_e  state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DLYW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]  drv_q, drv_d;
  logic [NCH-1:0]  pgood_q, pgood_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;
  logic            ovc_hit;

  // Over-current only counts on channels currently being driven.
  assign ovc_hit = |(ovc & drv_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    pgood_d = pgood_q;

    unique case (state_q)
      PS_OFF: begin
        if (en) begin
          state_d  = PS_UP;
          idx_d    = '0;
          cnt_d    = '0;
          drv_d[0] = 1'b1;
        end
      end

      PS_UP: begin
        if (ovc_hit) begin
          state_d = PS_FAULT;
        end else if (!en) begin
          // Abort: the channel being settled never reports good.
          state_d = PS_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          for (int unsigned k = 0; k < NCH; k++) begin
            if (k == 32'(idx_q)) pgood_d[k] = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            state_d = PS_ON;
          end else begin
            idx_d = idx_q + 1'b1;
            for (int unsigned k = 0; k < NCH; k++) begin
              if (k == 32'(idx_q) + 1) drv_d[k] = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PS_ON: begin
        if (ovc_hit) begin
          state_d = PS_FAULT;
        end else if (!en) begin
          state_d        = PS_DOWN;
          idx_d          = IDX_LAST;
          cnt_d          = '0;
          pgood_d[NCH-1] = 1'b0;
        end
      end

      PS_DOWN: begin
        if (ovc_hit) begin
          state_d = PS_FAULT;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          for (int unsigned k = 0; k < NCH; k++) begin
            if (k == 32'(idx_q)) drv_d[k] = 1'b0;
          end
          if (idx_q == '0) begin
            state_d = PS_OFF;
          end else begin
            // Next-lower channel loses good as its supply step begins.
            idx_d = idx_q - 1'b1;
            for (int unsigned k = 0; k < NCH; k++) begin
              if (k + 1 == 32'(idx_q)) pgood_d[k] = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PS_FAULT: begin
        if (!en) state_d = PS_OFF;
      end

      default: state_d = PS_OFF;
    endcase

    if (state_d == PS_FAULT) begin
      drv_d   = '0;
      pgood_d = '0;
      cnt_d   = '0;
      idx_d   = '0;
    end

    ready_d = (state_d == PS_ON);
    busy_d  = (state_d == PS_UP) || (state_d == PS_DOWN);
    fault_d = (state_d == PS_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      pgood_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      pgood_q <= pgood_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_pad
    pad_vdd_sw #(
      .ID(ID * PAD_NCH_MAX + k)
    ) u_sw (
      .drv(drv_q[k]),
      .pad(pad[k])
    );
  end

  assign pgood = pgood_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_pad_vdd_seq.sv
// Self-checking bench for pad_vdd_seq (NCH=4, DLY=16).
// The reference model tracks a mode plus the cycle at which the current
// ramp started and derives every channel's drive/good level from elapsed
// time with plain arithmetic.
module tb_pad_vdd_seq;

  localparam int NCH = 4;
  localparam int DLY = 16;

  localparam int M_OFF  = 0;
  localparam int M_RISE = 1;
  localparam int M_ON   = 2;
  localparam int M_FALL = 3;
  localparam int M_FLT  = 4;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [NCH-1:0] ovc;
  wire  [NCH-1:0] pad;
  logic [NCH-1:0] pgood;
  logic           ready;
  logic           busy;
  logic           fault;

  int total;
  int bad;

  int n;
  int mode;
  int t0;
  int top;
  logic [NCH-1:0] m_drv;
  logic [NCH-1:0] m_pg;

  pad_vdd_seq #(
    .ID  (3),
    .NCH (NCH),
    .DLYW(8),
    .DLY (DLY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .ovc  (ovc),
    .pad  (pad),
    .pgood(pgood),
    .ready(ready),
    .busy (busy),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  function automatic logic [NCH-1:0] pad_seen();
    logic [NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = (pad[k] === 1'b1);
    return v;
  endfunction

  task automatic model_reset();
    mode  = M_OFF;
    t0    = 0;
    top   = 0;
    m_drv = '0;
    m_pg  = '0;
  endtask

  // Advance the model across one rising edge using the inputs held at it.
  task automatic model_edge();
    int  e;
    logic hit;
    n++;
    hit = |(ovc & m_drv);
    e   = n - t0;
    case (mode)
      M_OFF:  if (en) begin mode = M_RISE; t0 = n; end
      M_RISE: begin
        if (hit) mode = M_FLT;
        else if (!en) begin mode = M_FALL; top = (e - 1) / DLY; t0 = n; end
        else if (e == NCH * DLY) mode = M_ON;
      end
      M_ON: begin
        if (hit) mode = M_FLT;
        else if (!en) begin mode = M_FALL; top = NCH - 1; t0 = n; end
      end
      M_FALL: begin
        if (hit) mode = M_FLT;
        else if (e == (top + 1) * DLY) mode = M_OFF;
      end
      default: if (!en) mode = M_OFF;
    endcase
    e = n - t0;
    m_drv = '0;
    m_pg  = '0;
    for (int k = 0; k < NCH; k++) begin
      case (mode)
        M_RISE: begin
          m_drv[k] = (k * DLY <= e);
          m_pg[k]  = ((k + 1) * DLY <= e);
        end
        M_ON: begin
          m_drv[k] = 1'b1;
          m_pg[k]  = 1'b1;
        end
        M_FALL: begin
          m_drv[k] = (k <= top) && (e < (top - k + 1) * DLY);
          m_pg[k]  = (k < top) && (e < (top - k) * DLY);
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    check("pad",   32'(pad_seen()), 32'(m_drv));
    check("pgood", 32'(pgood), 32'(m_pg));
    check("ready", 32'(ready), 32'(mode == M_ON));
    check("busy",  32'(busy), 32'(mode == M_RISE || mode == M_FALL));
    check("fault", 32'(fault), 32'(mode == M_FLT));
  endtask

  task automatic cyc(input logic e_in, input logic [NCH-1:0] o_in);
    en  = e_in;
    ovc = o_in;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input logic e_in, input int cycles);
    for (int i = 0; i < cycles; i++) cyc(e_in, '0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n     = 0;
    en    = 1'b0;
    ovc   = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full power-up, hold, full power-down.
    run(1'b1, 70);
    run(1'b0, 70);

    // Abort twenty edges into the ramp.
    run(1'b1, 21);
    run(1'b0, 40);

    // Over-current on a driven channel while on; held while en stays high.
    run(1'b1, 66);
    cyc(1'b1, 4'b0100);
    run(1'b1, 5);
    run(1'b0, 3);

    // Over-current on an undriven channel is ignored.
    run(1'b1, 5);
    cyc(1'b1, 4'b1000);
    run(1'b1, 62);
    // Over-current together with the en=0 edge: fault wins.
    cyc(1'b0, 4'b0001);
    run(1'b0, 3);

    // Asynchronous reset mid-ramp, between edges.
    run(1'b1, 30);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 70);
    run(1'b0, 70);

    // Randomized request and over-current traffic.
    begin
      int hold;
      logic e_r;
      logic [NCH-1:0] o_r;
      hold = 0;
      e_r  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (hold == 0) begin
          e_r  = ~e_r;
          hold = $urandom_range(1, 120);
        end
        hold--;
        o_r = '0;
        if ($urandom_range(0, 149) == 0) o_r[$urandom_range(0, NCH - 1)] = 1'b1;
        cyc(e_r, o_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
